// File: rtl/pll_lock_supervisor.sv
// Purpose: sequences PLL reset, waits for lock, qualifies it, then releases downstream reset.
// Latency: pll_locked reaches the FSM through a 2-flop synchronizer; outputs are registered with the state.
// Backpressure: none; this block is a free-running supervisor with no handshake.
//
// Ports:
//   inclk0        reference clock; the only clock used here
//   areset        asynchronous active-high reset
//   pll_locked    raw PLL lock flag, asynchronous to inclk0
//   pll_rst       registered active-high reset to the PLL
//   sys_reset     registered active-high reset to logic clocked by the PLL
//   ready         registered, high only while in RUN
//   lock_loss_cnt saturating count of lock losses seen in RUN
//   timeout_cnt   saturating count of lock-wait timeouts
//   state         current state: PLL_RST=0, WAIT_LOCK=1, STABILIZE=2, RUN=3
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024
) (
    input  logic       inclk0,
    input  logic       areset,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] lock_loss_cnt,
    output logic [7:0] timeout_cnt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABILIZE = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    // Wide enough for the largest legal LOCK_TIMEOUT.
    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q;
    logic             locked_s;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_hit;
    logic             lock_lost;

    // Two-flop synchronizer for the asynchronous lock flag.
    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            sync1_q  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            locked_s <= sync1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        lock_lost   = 1'b0;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock is tested first so it wins over a coincident timeout.
                if (locked_s) begin
                    state_d = S_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = S_PLL_RST;
                    timeout_hit = 1'b1;
                end
            end
            S_STABILIZE: begin
                // A dropout restarts the lock wait with a fresh timeout window.
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d   = S_PLL_RST;
                    lock_lost = 1'b1;
                end
            end
            default: state_d = S_PLL_RST;
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge
    // as the state register; sys_reset is high in every state except RUN,
    // which keeps it asserted whenever pll_rst is.
    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            state_q       <= S_PLL_RST;
            cnt_q         <= '0;
            pll_rst       <= 1'b1;
            sys_reset     <= 1'b1;
            ready         <= 1'b0;
            lock_loss_cnt <= 8'd0;
            timeout_cnt   <= 8'd0;
        end else begin
            state_q   <= state_d;
            pll_rst   <= (state_d == S_PLL_RST);
            sys_reset <= (state_d != S_RUN);
            ready     <= (state_d == S_RUN);
            // Shared counter: restarts on every state change, holds at max in RUN.
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout_hit && (timeout_cnt != 8'hFF)) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
            if (lock_lost && (lock_loss_cnt != 8'hFF)) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

    localparam int RST = 4;
    localparam int TO  = 20;
    localparam int ST  = 8;

    logic       inclk0 = 1'b0;
    logic       areset;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic [7:0] lock_loss_cnt;
    logic [7:0] timeout_cnt;
    logic [1:0] state;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q[$];

    pll_lock_supervisor #(
        .RST_CYCLES   (RST),
        .LOCK_TIMEOUT (TO),
        .STABLE_CYCLES(ST)
    ) dut (
        .inclk0       (inclk0),
        .areset       (areset),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .sys_reset    (sys_reset),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt),
        .timeout_cnt  (timeout_cnt),
        .state        (state)
    );

    always #10 inclk0 = ~inclk0;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge inclk0);
        #1;
    endtask

    task automatic push_exp(input int v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input int obs);
        int exp;
        n_assert++;
        if (exp_q.size() == 0) exp = -999;
        else exp = exp_q.pop_front();
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int probe(input int sel);
        int r;
        r = 0;
        case (sel)
            0: r = int'(pll_rst);
            1: r = int'(ready);
            2: r = int'(state);
            default: r = 0;
        endcase
        return r;
    endfunction

    // Counts edges until the probed signal equals val; -1 if the budget runs out.
    task automatic wait_sig(input int sel, input int val, input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (probe(sel) != val && cycles < budget);
        if (probe(sel) != val) cycles = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        push_exp(0); check({tag, "_state"},     int'(state));
        push_exp(1); check({tag, "_pll_rst"},   int'(pll_rst));
        push_exp(1); check({tag, "_sys_reset"}, int'(sys_reset));
        push_exp(0); check({tag, "_ready"},     int'(ready));
        push_exp(0); check({tag, "_lock_loss"}, int'(lock_loss_cnt));
        push_exp(0); check({tag, "_timeouts"},  int'(timeout_cnt));
    endtask

    initial begin
        int c;
        int missing;

        // Reset state
        areset     = 1'b1;
        pll_locked = 1'b0;
        repeat (3) tick();
        check_reset_outputs("por");

        // Nominal bring-up: pll_rst width, then lock qualified through sync + STABLE_CYCLES
        push_exp(RST);
        areset = 1'b0;
        wait_sig(0, 0, 20, c);
        check("nom_pll_rst_width", c);
        tick();
        tick();
        push_exp(2 + 1 + ST);
        pll_locked = 1'b1;
        wait_sig(1, 1, 50, c);
        check("nom_lock_to_ready", c);
        push_exp(0); check("nom_sys_reset", int'(sys_reset));
        push_exp(3); check("nom_state_run", int'(state));
        push_exp(0); check("nom_pll_rst",   int'(pll_rst));

        // Lock lost in RUN
        push_exp(3);
        pll_locked = 1'b0;
        wait_sig(2, 0, 10, c);
        check("loss_delay", c);
        push_exp(1); check("loss_sys_reset", int'(sys_reset));
        push_exp(0); check("loss_ready",     int'(ready));
        push_exp(1); check("loss_cnt",       int'(lock_loss_cnt));
        push_exp(1); check("loss_pll_rst",   int'(pll_rst));
        push_exp(RST);
        wait_sig(0, 0, 20, c);
        check("loss_pll_rst_width", c);

        // Stabilize abort: one-cycle dropout returns to WAIT_LOCK
        push_exp(3);
        pll_locked = 1'b1;
        wait_sig(2, 2, 10, c);
        check("abort_enter_stab", c);
        tick();
        tick();
        pll_locked = 1'b0;
        tick();
        push_exp(2);
        pll_locked = 1'b1;
        wait_sig(2, 1, 10, c);
        check("abort_back_to_wait", c);
        push_exp(1 + ST);
        wait_sig(2, 3, 30, c);
        check("abort_relock_to_run", c);
        push_exp(0); check("abort_timeouts", int'(timeout_cnt));

        // Lock arriving in the final timeout cycle wins
        push_exp(3);
        pll_locked = 1'b0;
        wait_sig(2, 0, 10, c);
        check("simul_loss_delay", c);
        push_exp(RST);
        wait_sig(0, 0, 20, c);
        check("simul_pll_rst_width", c);
        repeat (TO - 3) tick();
        pll_locked = 1'b1;
        tick();
        tick();
        push_exp(1); check("simul_state_last_wait", int'(state));
        tick();
        push_exp(2); check("simul_state_stab", int'(state));
        push_exp(0); check("simul_timeouts",   int'(timeout_cnt));
        push_exp(2); check("simul_lock_loss",  int'(lock_loss_cnt));

        // Asynchronous reset mid-STABILIZE, checked before any clock edge
        tick();
        tick();
        #4;
        areset     = 1'b1;
        pll_locked = 1'b0;
        #1;
        check_reset_outputs("async");
        repeat (2) tick();

        // Repeated timeouts and counter saturation
        push_exp(RST);
        areset = 1'b0;
        wait_sig(0, 0, 20, c);
        check("to_pll_rst_width", c);
        push_exp(TO);
        wait_sig(0, 1, 40, c);
        check("to_period_low", c);
        push_exp(1); check("to_first_count", int'(timeout_cnt));
        push_exp(RST);
        wait_sig(0, 0, 20, c);
        check("to_pll_rst_width2", c);
        missing = 0;
        for (int i = 0; i < 299; i++) begin
            wait_sig(0, 1, 40, c);
            if (c < 0) missing++;
            wait_sig(0, 0, 20, c);
            if (c < 0) missing++;
        end
        push_exp(0);   check("to_missing_pulses", missing);
        push_exp(255); check("to_saturated",      int'(timeout_cnt));
        push_exp(0);   check("to_lock_loss",      int'(lock_loss_cnt));
        push_exp(0);   check("to_ready",          int'(ready));

        n_assert++;
        assert (exp_q.size() === 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
